// File: rtl/lock_key_sequencer_pkg.sv
// lock_pkg: definitions shared by the week07 key-lock designs (key width, default code, sequencer states).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. Optional sequencer feature macro: LOCK_SEQ_PROGRESS_CHECK_EN.
package lock_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_KEYS = 4;

  // Key words in press order, press k at bits [4k+3:4k]: 0001, 0100, 1000, 0010
  localparam logic [KEY_W*NUM_KEYS-1:0] LOCK_CODE = 16'h2841;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RST         = 3'd1,
    ST_SETTLE      = 3'd2,
    ST_PRESS       = 3'd3,
    ST_GAP         = 3'd4,
    ST_WAIT_UNLOCK = 3'd5,
    ST_DONE        = 3'd6,
    ST_FAIL        = 3'd7
  } seq_state_t;

  // Pick key word idx out of a packed code
  function automatic logic [KEY_W-1:0] code_key(
    input logic [KEY_W*NUM_KEYS-1:0] code,
    input logic [1:0]                idx
  );
    code_key = code[idx*KEY_W +: KEY_W];
  endfunction

endpackage

// File: rtl/lock_key_sequencer_timer.sv
// lock_seq_timer: loadable down-counter with a zero flag, reused for the sequencer's timed states.
// Latency: a load takes effect at the next clock edge; o_zero reflects the current count.
// Backpressure: none; the count holds at zero until the next load.
module lock_seq_timer
  import lock_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on state entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lock_key_sequencer.sv
// lock_key_sequencer: resets the lock, plays a 4-key code as one-cycle presses and retries on failure.
// Latency: clean success raises done 1+SETTLE+4*(1+GAP)+2 cycles after the start cycle (17 by default).
// Backpressure: start is dropped while busy; all outputs registered. Optional macro: LOCK_SEQ_PROGRESS_CHECK_EN.
module lock_key_sequencer
  import lock_pkg::*;
#(
  parameter logic [KEY_W*NUM_KEYS-1:0] CODE      = LOCK_CODE,
  parameter int                        GAP       = 2,
  parameter int                        SETTLE    = 2,
  parameter int                        TIMEOUT   = 8,
  parameter int                        MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_progress,
  input  logic             i_unlock,
  output logic [KEY_W-1:0] o_keys,
  output logic             o_lock_rst,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [2:0]       o_attempts
);

  localparam int               TMR_W       = 8;
  localparam logic [TMR_W-1:0] SETTLE_LD   = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] GAP_LD      = TMR_W'(GAP - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD  = TMR_W'(TIMEOUT - 1);
  localparam logic [2:0]       MAX_RETRY_L = 3'(MAX_RETRY);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic [2:0]       r_attempts;
  logic [2:0]       w_attempts_nxt;
  logic [KEY_W-1:0] r_keys;
  logic [KEY_W-1:0] w_keys_nxt;
  logic             r_lock_rst;
  logic             w_lock_rst_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_fail;
  logic             w_fail_nxt;
  logic             w_start_acc;
  logic             w_att_fail;
  logic             w_prog_ok;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_zero;

  // Idle, done and fail are the only states that accept a new run
  assign w_start_acc = i_start &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL));

`ifdef LOCK_SEQ_PROGRESS_CHECK_EN
  // After press k the lock must report exactly progress bit k
  assign w_prog_ok = (i_progress == (KEY_W'(1) << r_idx));
`else
  // Progress feedback is not consulted; only unlock decides the outcome
  logic w_unused_progress;
  assign w_unused_progress = ^i_progress;
  assign w_prog_ok         = 1'b1;
`endif

  lock_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // State register plus the registered copies of every output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_attempts <= '0;
      r_keys     <= '0;
      r_lock_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_attempts <= w_attempts_nxt;
      r_keys     <= w_keys_nxt;
      r_lock_rst <= w_lock_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_fail     <= w_fail_nxt;
    end
  end

  // Next state and key index; a failed attempt re-resets the lock or gives up
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_att_fail  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (i_start) w_state_nxt = ST_RST;
      end
      ST_RST: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_tmr_zero) w_state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          if (!w_prog_ok) begin
            w_att_fail = 1'b1;
          end else if (r_idx == 2'd3) begin
            w_state_nxt = ST_WAIT_UNLOCK;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = ST_PRESS;
          end
        end
      end
      ST_WAIT_UNLOCK: begin
        if (i_unlock) begin
          w_state_nxt = ST_DONE;
        end else if (w_tmr_zero) begin
          w_att_fail = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_att_fail) begin
      w_state_nxt = (r_attempts <= MAX_RETRY_L) ? ST_RST : ST_FAIL;
    end
  end

  // Output values for the state being entered, plus timer reload on every state change
  always_comb begin
    w_keys_nxt     = (w_state_nxt == ST_PRESS) ? code_key(CODE, w_idx_nxt) : '0;
    w_lock_rst_nxt = (w_state_nxt == ST_RST);
    w_busy_nxt     = !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE) ||
                       (w_state_nxt == ST_FAIL));
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_fail_nxt     = (w_state_nxt == ST_FAIL);
    w_attempts_nxt = r_attempts;
    if (w_start_acc) begin
      w_attempts_nxt = 3'd1;
    end else if (w_att_fail && (w_state_nxt == ST_RST) && (r_attempts != 3'd7)) begin
      w_attempts_nxt = r_attempts + 3'd1;
    end
    w_tmr_load = (w_state_nxt != r_state);
    case (w_state_nxt)
      ST_SETTLE:      w_tmr_val = SETTLE_LD;
      ST_GAP:         w_tmr_val = GAP_LD;
      ST_WAIT_UNLOCK: w_tmr_val = TIMEOUT_LD;
      default:        w_tmr_val = '0;
    endcase
  end

  assign o_keys     = r_keys;
  assign o_lock_rst = r_lock_rst;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_fail     = r_fail;
  assign o_attempts = r_attempts;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// tb_lock_key_sequencer: drives lock_key_sequencer against a behavioural lock and a schedule model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_lock_key_sequencer;

  localparam int SETTLE    = 2;
  localparam int GAP       = 2;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;
  localparam int MAXC      = 96;

`ifdef LOCK_SEQ_PROGRESS_CHECK_EN
  localparam bit CHK     = 1'b1;
  localparam int E_WRONG = 19;
  localparam int E_FLAKY = 29;
  localparam int E_MIX   = 46;
`else
  localparam bit CHK     = 1'b0;
  localparam int E_WRONG = 70;
  localparam int E_FLAKY = 40;
  localparam int E_MIX   = 63;
`endif

  typedef struct {
    bit         wrong;     // lock programmed with 16'h2842 instead of the sequencer's code
    int         drop_att;  // attempt whose press drop_pos the lock ignores (0 = none)
    int         drop_pos;
    logic [2:0] withhold;  // bit a-1: lock never asserts unlock on attempt a
    int         spur;      // 0 none, 1 start on every busy cycle, 2 random starts while busy
  } cfg_t;

  typedef struct {
    bit done;
    bit fail;
    int att;
    int rsts;
    int endc;
  } obs_t;

  typedef struct {
    cfg_t cfg;
    obs_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [3:0] i_progress;
  logic       i_unlock;
  logic [3:0] o_keys;
  logic       o_lock_rst;
  logic       o_busy;
  logic       o_done;
  logic       o_fail;
  logic [2:0] o_attempts;

  int n_checks = 0;
  int n_fail   = 0;

  // Lock model state
  logic [15:0] lk_code;
  int          lk_drop_att;
  int          lk_drop_pos;
  logic [2:0]  lk_withhold;
  int          lk_att;
  int          lk_pos;
  int          lk_press;
  logic [3:0]  lk_prog_n;
  bit          lk_unl_n;

  // Expected per-cycle outputs of one run (cycle 0 = start cycle)
  logic [3:0] m_keys [MAXC];
  bit         m_rst  [MAXC];
  bit         m_busy [MAXC];
  bit         m_done [MAXC];
  bit         m_fail [MAXC];
  int         m_att  [MAXC];

  vec_t tbl [7];

  lock_key_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_progress (i_progress),
    .i_unlock   (i_unlock),
    .o_keys     (o_keys),
    .o_lock_rst (o_lock_rst),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_fail     (o_fail),
    .o_attempts (o_attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_key(input int k);
    case (k)
      0:       return 4'b0001;
      1:       return 4'b0100;
      2:       return 4'b1000;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic cfg_t mk_cfg(bit wr, int da, int dp, logic [2:0] wh, int sp);
    cfg_t c;
    c.wrong = wr; c.drop_att = da; c.drop_pos = dp; c.withhold = wh; c.spur = sp;
    return c;
  endfunction

  function automatic obs_t mk_obs(bit d, bit f, int at, int rs, int ec);
    obs_t o;
    o.done = d; o.fail = f; o.att = at; o.rsts = rs; o.endc = ec;
    return o;
  endfunction

  // Registered lock: reacts to keys/lock_rst of cycle c and shows the result in cycle c+1
  initial begin
    i_progress = '0;
    i_unlock   = 1'b0;
    lk_pos     = 0;
    lk_press   = 0;
    lk_prog_n  = '0;
    lk_unl_n   = 1'b0;
    forever begin
      @(negedge clk);
      if (o_lock_rst) begin
        lk_att    = lk_att + 1;
        lk_pos    = 0;
        lk_press  = 0;
        lk_prog_n = '0;
        lk_unl_n  = 1'b0;
      end else if (o_keys != 4'd0) begin
        if (!(lk_att == lk_drop_att && lk_press == lk_drop_pos)) begin
          if (lk_pos < 4 && o_keys == lk_code[4*lk_pos +: 4]) begin
            lk_prog_n = 4'd1 << lk_pos;
            lk_pos    = lk_pos + 1;
            if (lk_pos == 4)
              lk_unl_n = !(lk_att >= 1 && lk_att <= 3 && lk_withhold[lk_att-1]);
          end else begin
            lk_pos    = 0;
            lk_prog_n = '0;
          end
        end
        lk_press = lk_press + 1;
      end
      @(posedge clk);
      #1;
      i_progress = lk_prog_n;
      i_unlock   = lk_unl_n;
    end
  end

  // Attempt schedule: RST at r, press k at r+1+SETTLE+k*(1+GAP), unlock wait from r+1+SETTLE+4*(1+GAP)
  task automatic build_model(input cfg_t cfg, output int endc);
    int r, a, bad, npress, w, nxt;
    bit fin, succ;
    for (int c = 0; c < MAXC; c++) begin
      m_keys[c] = '0; m_rst[c] = 0; m_busy[c] = 0; m_done[c] = 0; m_fail[c] = 0; m_att[c] = 0;
    end
    r = 1; a = 1; fin = 0; succ = 0; endc = 0; nxt = 0;
    while (!fin) begin
      m_rst[r] = 1;
      for (int c = r; c < MAXC; c++) m_att[c] = a;
      bad    = cfg.wrong ? 0 : ((cfg.drop_att == a) ? cfg.drop_pos : 4);
      npress = (CHK && bad < 4) ? bad + 1 : 4;
      for (int k = 0; k < npress; k++) m_keys[r + 1 + SETTLE + k*(1 + GAP)] = exp_key(k);
      w = r + 1 + SETTLE + 4*(1 + GAP);
      if (CHK && bad < 4) begin
        nxt = r + 1 + SETTLE + bad*(1 + GAP) + GAP + 1;
      end else if (bad == 4 && !cfg.withhold[a-1]) begin
        endc = w + 1; succ = 1; fin = 1;
      end else begin
        nxt = w + TIMEOUT;
      end
      if (!fin) begin
        if (a <= MAX_RETRY) begin
          r = nxt; a = a + 1;
        end else begin
          endc = nxt; fin = 1;
        end
      end
    end
    for (int c = 1; c < endc; c++) m_busy[c] = 1;
    for (int c = endc; c < MAXC; c++) begin
      m_done[c] = succ;
      m_fail[c] = !succ;
    end
  endtask

  // Entered 1 unit after a rising edge with the block idle/done/fail; leaves at the same phase
  task automatic run_case(input int id, input cfg_t cfg, output obs_t o);
    int endc;
    logic [31:0] got, expv;
    build_model(cfg, endc);
    lk_code     = cfg.wrong ? 16'h2842 : 16'h2841;
    lk_drop_att = cfg.drop_att;
    lk_drop_pos = cfg.drop_pos;
    lk_withhold = cfg.withhold;
    lk_att      = 0;
    o = mk_obs(0, 0, 0, 0, 0);
    i_start = 1'b1;
    for (int c = 1; c <= endc + 2; c++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      got  = {21'd0, o_keys, o_lock_rst, o_busy, o_done, o_fail, o_attempts};
      expv = {21'd0, m_keys[c], m_rst[c], m_busy[c], m_done[c], m_fail[c], 3'(m_att[c])};
      check($sformatf("run%0d_cyc%0d {keys,rst,busy,done,fail,att}", id, c), got, expv);
      if (o_lock_rst) o.rsts++;
      if (o.endc == 0 && (o_done || o_fail)) o.endc = c;
      if (m_busy[c] && (cfg.spur == 1 || (cfg.spur == 2 && $urandom_range(0, 2) == 0)))
        i_start = 1'b1;
    end
    i_start = 1'b0;
    o.done = o_done;
    o.fail = o_fail;
    o.att  = int'(o_attempts);
  endtask

  initial begin
    obs_t ob;
    cfg_t rc;
    int   ec;

    lk_code = 16'h2841; lk_drop_att = 0; lk_drop_pos = 0; lk_withhold = '0; lk_att = 0;

    tbl[0] = '{mk_cfg(0, 0, 0, 3'b000, 0), mk_obs(1, 0, 1, 1, 17)};       // nominal
    tbl[1] = '{mk_cfg(1, 0, 0, 3'b000, 0), mk_obs(0, 1, 3, 3, E_WRONG)};  // wrong code
    tbl[2] = '{mk_cfg(0, 1, 2, 3'b000, 0), mk_obs(1, 0, 2, 2, E_FLAKY)};  // key 2 lost once
    tbl[3] = '{mk_cfg(0, 0, 0, 3'b111, 0), mk_obs(0, 1, 3, 3, 70)};       // never unlocks
    tbl[4] = '{mk_cfg(0, 0, 0, 3'b001, 0), mk_obs(1, 0, 2, 2, 40)};       // timeout once
    tbl[5] = '{mk_cfg(0, 2, 0, 3'b001, 0), mk_obs(1, 0, 3, 3, E_MIX)};    // timeout, drop, ok
    tbl[6] = '{mk_cfg(0, 0, 0, 3'b000, 1), mk_obs(1, 0, 1, 1, 17)};       // starts while busy

    // Reset values, and reset beating a simultaneous start
    reset   = 1'b1;
    i_start = 1'b0;
    #2;
    check("reset_outputs", {21'd0, o_keys, o_lock_rst, o_busy, o_done, o_fail, o_attempts}, 32'd0);
    i_start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_wins_over_start", {21'd0, o_keys, o_lock_rst, o_busy, o_done, o_fail, o_attempts}, 32'd0);
    i_start = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_case(i, tbl[i].cfg, ob);
      check($sformatf("tbl%0d_done", i),     32'(ob.done), 32'(tbl[i].exp.done));
      check($sformatf("tbl%0d_fail", i),     32'(ob.fail), 32'(tbl[i].exp.fail));
      check($sformatf("tbl%0d_attempts", i), 32'(ob.att),  32'(tbl[i].exp.att));
      check($sformatf("tbl%0d_lock_rst", i), 32'(ob.rsts), 32'(tbl[i].exp.rsts));
      check($sformatf("tbl%0d_end_cycle", i), 32'(ob.endc), 32'(tbl[i].exp.endc));
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset asserted during the second press
    lk_code = 16'h2841; lk_drop_att = 0; lk_withhold = '0; lk_att = 0;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    check("mid_second_press_keys", 32'(o_keys), 32'h4);
    reset = 1'b1;
    #1;
    check("mid_reset_async", {21'd0, o_keys, o_lock_rst, o_busy, o_done, o_fail, o_attempts}, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_idle", {21'd0, o_keys, o_lock_rst, o_busy, o_done, o_fail, o_attempts}, 32'd0);
    run_case(100, mk_cfg(0, 0, 0, 3'b000, 0), ob);
    check("post_reset_done", 32'(ob.done), 32'd1);
    check("post_reset_end_cycle", 32'(ob.endc), 32'd17);

    // Randomised lock behaviour and stray starts
    for (int n = 0; n < 25; n++) begin
      rc.wrong    = ($urandom_range(0, 7) == 0);
      rc.drop_att = $urandom_range(0, 3);
      rc.drop_pos = $urandom_range(0, 3);
      rc.withhold = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
      rc.spur     = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_case(200 + n, rc, ob);
      build_model(rc, ec);
      check($sformatf("rnd%0d_end_cycle", n), 32'(ob.endc), 32'(ec));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_key_sequencer.md
Name: lock_key_sequencer

Overview:
- Initiator-side companion to the key-lock FSM (moore_state_machine).
- On a `start` pulse it resets the lock and plays a programmed 4-key code as single-cycle one-hot key presses with idle gaps.
- It monitors the lock's `progress`/`unlock` feedback and retries on failure.
- Used as a self-test driver and as an automated unlock agent in the week07 lock designs.

Parameters:
- CODE, 16'h2841: key words in press order; press k drives CODE[4k+3:4k], so k0=0001, k1=0100, k2=1000, k3=0010.
- GAP, 2: idle cycles (keys=0) after each press; legal range ≥1.
- SETTLE, 2: cycles between `lock_rst` and the first press; legal range ≥2.
- TIMEOUT, 8: cycles to wait for `unlock` after the last gap; legal range ≥1.
- MAX_RETRY, 2: retries after the first failed attempt; total attempts = MAX_RETRY+1 ≤ 7.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: one-cycle request; ignored while busy.
- progress, input, 4: lock progress feedback; one-hot bit k is expected after press k.
- unlock, input, 1: lock unlocked indication.
- keys, output, 4: key drive; registered; nonzero for exactly one cycle per press.
- lock_rst, output, 1: registered reset pulse to the lock, one cycle per attempt.
- busy, output, 1: high from the cycle after start until done/fail.
- done, output, 1: level; set on success, cleared by the next accepted start.
- fail, output, 1: level; set when all attempts fail, cleared by the next accepted start.
- attempts, output, 3: number of attempts started in the current run.

Behaviour:
- Reset values: keys=0, lock_rst=0, busy=0, done=0, fail=0, attempts=0, state=IDLE, key index=0, counters=0. Reset wins over a simultaneous start.
- All outputs are registered; there are no combinational input-to-output paths.
- States: IDLE, RST, SETTLE, PRESS, GAP, WAIT_UNLOCK, DONE, FAIL.
- IDLE: on start=1, clear done/fail, set attempts=1, go to RST. Outside IDLE/DONE/FAIL, start is ignored.
- RST: lock_rst=1 for this one cycle; key index=0; go to SETTLE.
- SETTLE: keys=0; count SETTLE cycles, then go to PRESS.
- PRESS: keys=CODE[idx] for exactly one cycle; go to GAP.
- GAP: keys=0 for GAP cycles. On the last GAP cycle, evaluate the progress check (see Optional Feature):
  - check fails → attempt fails;
  - idx<3 → idx++, go to PRESS;
  - idx=3 → go to WAIT_UNLOCK.
- WAIT_UNLOCK: keys=0. If unlock=1 → DONE. If TIMEOUT cycles elapse without unlock → attempt fails.
- Attempt failure:
  - attempts ≤ MAX_RETRY → attempts++, go to RST (the lock is re-reset);
  - otherwise → FAIL.
- DONE: done=1, busy=0. FAIL: fail=1, busy=0. Both behave like IDLE for start, so a new start re-arms the block.
- Clean success latency: done rises at most 1+SETTLE+4·(1+GAP)+2 cycles after the start cycle; with defaults this is ≤17.
- unlock=1 observed during PRESS/GAP is not acted on early; it is checked only in WAIT_UNLOCK.
- Asserting reset mid-sequence aborts immediately: keys=0 and lock_rst=0 take effect asynchronously.
- The attempts counter saturates at 7.

Optional Feature:
- Macro: LOCK_SEQ_PROGRESS_CHECK_EN.
- Defined: at the last GAP cycle after press k, progress must equal 4'b0001<<k. Any mismatch fails the attempt immediately, without waiting for the remaining presses.
- Undefined: progress is ignored (the port stays present but unused). All four presses are always sent, and success/failure is decided only by unlock within TIMEOUT.

Decomposition:
- Shared package lock_pkg holds:
  - state encoding constants for IDLE…FAIL (3 bits);
  - the default code 16'h2841;
  - KEY_W=4.
- The lock FSM and this block share KEY_W and the code constant.
- One natural sub-module: lock_seq_timer, a loadable down-counter with a zero flag. It is reused for the SETTLE, GAP and TIMEOUT counts; the FSM loads it on each state entry.

Test Plan:
- Nominal: connect to moore_state_machine, pulse start → lock_rst for 1 cycle; keys sequence 0001,0100,1000,0010, each one cycle, separated by 2 zero cycles; done=1 by cycle 17; attempts=1; fail=0.
- Wrong code: CODE=16'h2842, MAX_RETRY=2 → three lock_rst pulses; fail=1, done=0, attempts=3. With LOCK_SEQ_PROGRESS_CHECK_EN defined, each attempt aborts after the first press.
- Flaky lock: the bench model drops key 2 on attempt 1 only → second attempt succeeds; done=1, attempts=2.
- Timeout: the bench holds unlock=0 while progress is correct → after TIMEOUT=8 cycles in WAIT_UNLOCK, the block retries; with MAX_RETRY=0, fail=1.
- Busy/start: start pulses mid-sequence are ignored (attempts unchanged, no extra lock_rst). Start after done clears done on the next cycle and restarts.
- Reset mid-operation: assert reset during the second PRESS → keys=0 asynchronously, all outputs at reset values; a subsequent start runs a clean sequence.
